// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the draw pipeline.
// Latency: none, wires only.
// Backpressure: none; the generator is throttled only by pix_ce and en.
interface vga_timing_gen_if #(
    parameter int CNT_W = 11
);
    logic             pix_ce;
    logic             en;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic             de;
    logic             line_start;
    logic             frame_start;
    logic             busy;

    // Timing generator side: takes the controls, drives the raster.
    modport master (
        input  pix_ce, en,
        output hcount, vcount, hsync, vsync, hblnk, vblnk, de,
               line_start, frame_start, busy
    );

    // Consumer/controller side: drives the controls, observes the raster.
    modport slave (
        output pix_ce, en,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, de,
               line_start, frame_start, busy
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with sync polarity, pixel enable and run FSM.
// Latency: one clk from pix_ce/en to registered counters and flags (flags share the counter edge).
// Backpressure: none; pix_ce=0 freezes the raster, en only acts at frame boundaries.
module vga_timing_gen #(
    parameter int CNT_W  = 11,
    parameter int H_ACT  = 800,
    parameter int H_FP   = 40,
    parameter int H_SYNC = 128,
    parameter int H_BP   = 88,
    parameter int V_ACT  = 600,
    parameter int V_FP   = 1,
    parameter int V_SYNC = 4,
    parameter int V_BP   = 23,
    parameter bit H_POL  = 1'b1,
    parameter bit V_POL  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vga_timing_gen_if.master     vid
);
    localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

    // Reject degenerate timings and counters too narrow for the raster.
    if (H_ACT == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACT == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        longint'(H_TOT) > (longint'(1) << CNT_W) ||
        longint'(V_TOT) > (longint'(1) << CNT_W)) begin : g_param_err
        $error("vga_timing_gen: zero timing parameter or CNT_W too small for H_TOT/V_TOT");
    end

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] HS_ON   = CNT_W'(H_ACT + H_FP);
    localparam logic [CNT_W-1:0] HS_OFF  = CNT_W'(H_ACT + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_ON   = CNT_W'(V_ACT + V_FP);
    localparam logic [CNT_W-1:0] VS_OFF  = CNT_W'(V_ACT + V_FP + V_SYNC);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] nxt_h;
    logic [CNT_W-1:0] nxt_v;
    logic             nxt_ls;
    logic             nxt_fs;
    logic             nxt_hblnk;
    logic             nxt_vblnk;
    logic             nxt_hsync;
    logic             nxt_vsync;
    logic             nxt_de;
    logic             eol;
    logic             eof;

    // Next raster position and strobes; en is only honoured at the frame wrap.
    always_comb begin
        eol       = (vid.hcount == H_LAST);
        eof       = eol && (vid.vcount == V_LAST);
        nxt_state = state;
        nxt_h     = vid.hcount;
        nxt_v     = vid.vcount;
        nxt_ls    = 1'b0;
        nxt_fs    = 1'b0;
        case (state)
            IDLE: begin
                if (vid.en && vid.pix_ce) begin
                    nxt_state = RUN;
                    nxt_h     = '0;
                    nxt_v     = '0;
                    nxt_ls    = 1'b1;
                    nxt_fs    = 1'b1;
                end
            end
            RUN: begin
                if (vid.pix_ce) begin
                    if (eof) begin
                        nxt_h = '0;
                        nxt_v = '0;
                        if (vid.en) begin
                            nxt_ls = 1'b1;
                            nxt_fs = 1'b1;
                        end else begin
                            nxt_state = IDLE;
                        end
                    end else if (eol) begin
                        nxt_h  = '0;
                        nxt_v  = vid.vcount + CNT_W'(1);
                        nxt_ls = 1'b1;
                    end else begin
                        nxt_h = vid.hcount + CNT_W'(1);
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Flags derived from the next counters so they land on the same edge as the counts.
    always_comb begin
        nxt_hblnk = (nxt_h >= H_ACT_C);
        nxt_vblnk = (nxt_v >= V_ACT_C);
        nxt_hsync = ((nxt_h >= HS_ON) && (nxt_h < HS_OFF)) ^ ~H_POL;
        nxt_vsync = ((nxt_v >= VS_ON) && (nxt_v < VS_OFF)) ^ ~V_POL;
        nxt_de    = (nxt_state == RUN) && !nxt_hblnk && !nxt_vblnk;
    end

    // Run FSM and registered raster outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            vid.hcount      <= '0;
            vid.vcount      <= '0;
            vid.hsync       <= ~H_POL;
            vid.vsync       <= ~V_POL;
            vid.hblnk       <= 1'b0;
            vid.vblnk       <= 1'b0;
            vid.de          <= 1'b0;
            vid.line_start  <= 1'b0;
            vid.frame_start <= 1'b0;
            vid.busy        <= 1'b0;
        end else begin
            state           <= nxt_state;
            vid.hcount      <= nxt_h;
            vid.vcount      <= nxt_v;
            vid.hsync       <= nxt_hsync;
            vid.vsync       <= nxt_vsync;
            vid.hblnk       <= nxt_hblnk;
            vid.vblnk       <= nxt_vblnk;
            vid.de          <= nxt_de;
            vid.line_start  <= nxt_ls;
            vid.frame_start <= nxt_fs;
            vid.busy        <= (nxt_state == RUN);
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (active-high and active-low syncs).
// Latency: outputs compared 1ns after each clk edge against a pixel-index model.
// Backpressure: pix_ce/en/rst_n driven per clk from directed phases and $urandom.
module tb_vga_timing_gen;
    localparam int CW    = 5;
    localparam int HA    = 8;
    localparam int HF    = 2;
    localparam int HS    = 3;
    localparam int HB    = 2;
    localparam int VA    = 5;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int HT    = HA + HF + HS + HB;
    localparam int VT    = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    // Reference model: a run flag plus a linear pixel index within the frame.
    bit m_run = 1'b0;
    int m_p   = 0;
    bit m_ls  = 1'b0;
    bit m_fs  = 1'b0;

    vga_timing_gen_if #(.CNT_W(CW)) ifa ();
    vga_timing_gen_if #(.CNT_W(CW)) ifb ();

    vga_timing_gen #(
        .CNT_W(CW), .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(1'b1), .V_POL(1'b1)
    ) dut_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (ifa)
    );

    vga_timing_gen #(
        .CNT_W(CW), .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(1'b0), .V_POL(1'b0)
    ) dut_neg (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit c);
        m_ls = 1'b0;
        m_fs = 1'b0;
        if (!r) begin
            m_run = 1'b0;
            m_p   = 0;
        end else if (!m_run) begin
            if (e && c) begin
                m_run = 1'b1;
                m_p   = 0;
                m_ls  = 1'b1;
                m_fs  = 1'b1;
            end
        end else if (c) begin
            if (m_p == FRAME - 1) begin
                m_p = 0;
                if (e) begin
                    m_ls = 1'b1;
                    m_fs = 1'b1;
                end else begin
                    m_run = 1'b0;
                end
            end else begin
                m_p++;
                m_ls = (m_p % HT) == 0;
            end
        end
    endtask

    task automatic check_all();
        int  h, v;
        bit  hs_in, vs_in;
        h     = m_p % HT;
        v     = m_p / HT;
        hs_in = (h >= HA + HF) && (h < HA + HF + HS);
        vs_in = (v >= VA + VF) && (v < VA + VF + VS);
        chk("hcount",      32'(ifa.hcount),      32'(h));
        chk("vcount",      32'(ifa.vcount),      32'(v));
        chk("hsync",       32'(ifa.hsync),       32'(hs_in));
        chk("vsync",       32'(ifa.vsync),       32'(vs_in));
        chk("hblnk",       32'(ifa.hblnk),       32'(h >= HA));
        chk("vblnk",       32'(ifa.vblnk),       32'(v >= VA));
        chk("de",          32'(ifa.de),          32'(m_run && h < HA && v < VA));
        chk("line_start",  32'(ifa.line_start),  32'(m_ls));
        chk("frame_start", 32'(ifa.frame_start), 32'(m_fs));
        chk("busy",        32'(ifa.busy),        32'(m_run));
        chk("neg_hcount",  32'(ifb.hcount),      32'(h));
        chk("neg_vcount",  32'(ifb.vcount),      32'(v));
        chk("neg_hsync",   32'(ifb.hsync),       32'(!hs_in));
        chk("neg_vsync",   32'(ifb.vsync),       32'(!vs_in));
        chk("neg_de",      32'(ifb.de),          32'(m_run && h < HA && v < VA));
    endtask

    task automatic cycle(input bit r, input bit e, input bit c);
        rst_n      = r;
        ifa.en     = e;
        ifa.pix_ce = c;
        ifb.en     = e;
        ifb.pix_ce = c;
        @(posedge clk);
        model_step(r, e, c);
        #1;
        check_all();
    endtask

    // Clocks between two frame_start pulses with pix_ce asserted 1 clk in every div.
    task automatic measure(input string tag, input int div);
        int k, n;
        bit seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 3 * FRAME * div) begin
            cycle(1'b1, 1'b1, (k % div) == 0);
            k++;
            seen = (ifa.frame_start === 1'b1);
        end
        n    = 0;
        seen = 1'b0;
        while (seen == 1'b0 && n < 3 * FRAME * div) begin
            cycle(1'b1, 1'b1, (k % div) == 0);
            k++;
            n++;
            seen = (ifa.frame_start === 1'b1);
        end
        chk(tag, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(FRAME * div));
    endtask

    initial begin
        int guard;
        int last_h, last_v;
        bit e;
        rst_n      = 1'b0;
        ifa.en     = 1'b0;
        ifa.pix_ce = 1'b0;
        ifb.en     = 1'b0;
        ifb.pix_ce = 1'b0;

        // Reset state.
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        chk("rst_neg_hsync", 32'(ifb.hsync), 32'd1);
        // Idle hold while en=0.
        repeat (4) cycle(1'b1, 1'b0, 1'b1);

        // First start: (0,0) with both strobes, then hcount=1.
        cycle(1'b1, 1'b1, 1'b1);
        chk("start_fs", 32'(ifa.frame_start), 32'd1);
        chk("start_de", 32'(ifa.de), 32'd1);
        cycle(1'b1, 1'b1, 1'b1);
        chk("second_h", 32'(ifa.hcount), 32'd1);

        // Free-run and 1-in-4 pixel enable frame periods.
        measure("period_ce1", 1);
        measure("period_ce4", 4);

        // en dropped mid-frame: frame completes, then idle, then restart.
        guard = 0;
        while (m_p != 4 * HT + 6 && guard < 2 * FRAME) begin
            cycle(1'b1, 1'b1, 1'b1);
            guard++;
        end
        chk("reach_drop_pt", 32'(m_p), 32'(4 * HT + 6));
        last_h = 0;
        last_v = 0;
        guard  = 0;
        while (m_run && guard < 2 * FRAME) begin
            last_h = 32'(ifa.hcount);
            last_v = 32'(ifa.vcount);
            cycle(1'b1, 1'b0, 1'b1);
            guard++;
        end
        chk("drop_last_h", 32'(last_h), 32'(HT - 1));
        chk("drop_last_v", 32'(last_v), 32'(VT - 1));
        chk("drop_busy", 32'(ifa.busy), 32'd0);
        repeat (5) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        chk("restart_fs", 32'(ifa.frame_start), 32'd1);

        // Reset mid-frame aborts at once, then clean restart.
        guard = 0;
        while (m_p != 3 * HT + 9 && guard < 2 * FRAME) begin
            cycle(1'b1, 1'b1, 1'b1);
            guard++;
        end
        cycle(1'b0, 1'b1, 1'b1);
        chk("midrst_busy", 32'(ifa.busy), 32'd0);
        chk("midrst_h", 32'(ifa.hcount), 32'd0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("midrst_restart_fs", 32'(ifa.frame_start), 32'd1);

        // Randomized controls: sparse en toggles, bursty pix_ce, rare resets.
        e = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) e = ~e;
            cycle($urandom_range(0, 599) != 0, e, $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
